// File: rtl/aqalu_vector_sequencer.sv
// aqalu_vector_sequencer
// Stores a small table of AQALU test vectors, drives each one onto the ALU
// inputs, waits a fixed settle time and compares the ALU result against the
// stored expected value. Pass/fail/skip counters saturate; the most recent
// mismatch is captured for inspection.
// Optional build macro: STOP_ON_FAIL_EN -- when defined, the first mismatch
// ends the run immediately.
module aqalu_vector_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic [ADDR_W:0]   vec_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        alu_a,
    output logic [1:0]        alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [CNT_W-1:0]  skip_count,
    output logic              mismatch_valid,
    output logic [ADDR_W-1:0] mismatch_index,
    output logic [7:0]        mismatch_expected,
    output logic [7:0]        mismatch_actual
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);
    localparam logic [3:0]        SKIP_OP   = 4'd14;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    logic [15:0] table_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        exp_q, exp_d;
    logic [1:0]        a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
    logic              mv_q, mv_d;
    logic [ADDR_W-1:0] mi_q, mi_d;
    logic [7:0]        me_q, me_d, ma_q, ma_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              idle_s;
    logic [15:0]       entry_s;
    logic [ADDR_W:0]   clamp_s;
    logic [ADDR_W:0]   idx_inc_s;
    logic              mismatch_s;

    assign idle_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Table write port; writes are only accepted while no run is in progress.
    always_ff @(posedge clock) begin
        if (load_we && idle_s && !reset) begin
            table_q[load_addr] <= load_data;
        end
    end

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        exp_d      = exp_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        skip_d     = skip_q;
        mv_d       = mv_q;
        mi_d       = mi_q;
        me_d       = me_q;
        ma_d       = ma_q;
        entry_s    = table_q[idx_q[ADDR_W-1:0]];
        clamp_s    = (vec_count > DEPTH_C) ? DEPTH_C : vec_count;
        idx_inc_s  = idx_q + IDX_ONE;
        mismatch_s = (op_q < SKIP_OP) && (alu_result != exp_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d  = clamp_s;
                    idx_d  = '0;
                    pass_d = '0;
                    fail_d = '0;
                    skip_d = '0;
                    mv_d   = 1'b0;
                    mi_d   = '0;
                    me_d   = 8'd0;
                    ma_d   = 8'd0;
                    if (clamp_s == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                a_d     = entry_s[15:14];
                b_d     = entry_s[13:12];
                op_d    = entry_s[11:8];
                exp_d   = entry_s[7:0];
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_CHECK: begin
                if (op_q >= SKIP_OP) begin
                    skip_d = sat_inc(skip_q);
                end else if (!mismatch_s) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    mv_d   = 1'b1;
                    mi_d   = idx_q[ADDR_W-1:0];
                    me_d   = exp_q;
                    ma_d   = alu_result;
                end
                idx_d = idx_inc_s;
`ifdef STOP_ON_FAIL_EN
                if ((idx_inc_s == cnt_q) || mismatch_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
`else
                if (idx_inc_s == cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            exp_q   <= 8'd0;
            a_q     <= 2'd0;
            b_q     <= 2'd0;
            op_q    <= 4'd0;
            pass_q  <= '0;
            fail_q  <= '0;
            skip_q  <= '0;
            mv_q    <= 1'b0;
            mi_q    <= '0;
            me_q    <= 8'd0;
            ma_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            exp_q   <= exp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            skip_q  <= skip_d;
            mv_q    <= mv_d;
            mi_q    <= mi_d;
            me_q    <= me_d;
            ma_q    <= ma_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign alu_a             = a_q;
    assign alu_b             = b_q;
    assign alu_opcode        = op_q;
    assign pass_count        = pass_q;
    assign fail_count        = fail_q;
    assign skip_count        = skip_q;
    assign mismatch_valid    = mv_q;
    assign mismatch_index    = mi_q;
    assign mismatch_expected = me_q;
    assign mismatch_actual   = ma_q;

endmodule

// File: tb/tb_aqalu_vector_sequencer.sv
// Directed testbench for aqalu_vector_sequencer with a small AQALU model
// (op0 = A+B, op1 = A-B, op2 = A&B, others 0) driving alu_result.
module tb_aqalu_vector_sequencer;

    localparam int SETTLE = 1;
    localparam int PER    = SETTLE + 2;

    logic       clock;
    logic       reset;
    logic       load_we;
    logic [3:0] load_addr;
    logic [15:0] load_data;
    logic [4:0] vec_count;
    logic       start;
    logic       busy, done;
    logic [1:0] alu_a, alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic [7:0] pass_count, fail_count, skip_count;
    logic       mismatch_valid;
    logic [3:0] mismatch_index;
    logic [7:0] mismatch_expected, mismatch_actual;
    logic       use_model;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    localparam logic [15:0] V0 = {2'd1, 2'd2, 4'd0, 8'd3};
    localparam logic [15:0] V1 = {2'd3, 2'd3, 4'd0, 8'd6};
    localparam logic [15:0] V2 = {2'd2, 2'd1, 4'd1, 8'd1};
    localparam logic [15:0] V3 = {2'd1, 2'd1, 4'd2, 8'd1};

    aqalu_vector_sequencer #(.DEPTH(16), .ADDR_W(4), .SETTLE(SETTLE), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .vec_count(vec_count), .start(start),
        .busy(busy), .done(done), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result),
        .pass_count(pass_count), .fail_count(fail_count), .skip_count(skip_count),
        .mismatch_valid(mismatch_valid), .mismatch_index(mismatch_index),
        .mismatch_expected(mismatch_expected), .mismatch_actual(mismatch_actual)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference AQALU; a fixed junk value replaces it for the skip test.
    always_comb begin
        if (!use_model) begin
            alu_result = 8'hAA;
        end else begin
            case (alu_opcode)
                4'd0:    alu_result = 8'({6'd0, alu_a} + {6'd0, alu_b});
                4'd1:    alu_result = 8'({6'd0, alu_a} - {6'd0, alu_b});
                4'd2:    alu_result = {6'd0, alu_a & alu_b};
                default: alu_result = 8'd0;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clock);
        load_we = 1'b1; load_addr = addr; load_data = data;
        @(posedge clock);
        #1 load_we = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle write); cycles counts edges
    // after the start-sampling edge until done is seen.
    task automatic run(input logic [4:0] cnt, input logic we, input logic [3:0] addr,
                       input logic [15:0] data, output int cycles);
        @(negedge clock);
        vec_count = cnt; start = 1'b1;
        load_we = we; load_addr = addr; load_data = data;
        @(posedge clock);
        #1 start = 1'b0; load_we = 1'b0;
        cycles = 0;
        while (!done && cycles < 500) begin
            @(posedge clock);
            #1 cycles++;
        end
        if (!done) check_eq("run_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; load_we = 1'b0; load_addr = 4'd0; load_data = 16'd0;
        vec_count = 5'd0; start = 1'b0; use_model = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass_count), 32'd0);
        check_eq("rst_alu_op", 32'(alu_opcode), 32'd0);
        check_eq("rst_mv", 32'(mismatch_valid), 32'd0);

        // All three vectors pass.
        load(4'd0, V0); load(4'd1, V1); load(4'd2, V2);
        run(5'd3, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("p3_cycles", 32'(cyc), 32'(3 * PER));
        check_eq("p3_pass", 32'(pass_count), 32'd3);
        check_eq("p3_fail", 32'(fail_count), 32'd0);
        check_eq("p3_skip", 32'(skip_count), 32'd0);
        check_eq("p3_mv", 32'(mismatch_valid), 32'd0);
        check_eq("p3_busy", 32'(busy), 32'd0);
        check_eq("p3_alu_a", 32'(alu_a), 32'd2);
        check_eq("p3_alu_op", 32'(alu_opcode), 32'd1);

        // Vector 1 with a wrong expected value.
        load(4'd1, {2'd3, 2'd3, 4'd0, 8'd7});
        run(5'd3, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("f_fail", 32'(fail_count), 32'd1);
        check_eq("f_mv", 32'(mismatch_valid), 32'd1);
        check_eq("f_idx", 32'(mismatch_index), 32'd1);
        check_eq("f_exp", 32'(mismatch_expected), 32'd7);
        check_eq("f_act", 32'(mismatch_actual), 32'd6);
`ifdef STOP_ON_FAIL_EN
        check_eq("f_cycles", 32'(cyc), 32'(2 * PER));
        check_eq("f_pass", 32'(pass_count), 32'd1);
        check_eq("f_alu_a", 32'(alu_a), 32'd3);
`else
        check_eq("f_cycles", 32'(cyc), 32'(3 * PER));
        check_eq("f_pass", 32'(pass_count), 32'd2);
        check_eq("f_alu_a", 32'(alu_a), 32'd2);
`endif
        load(4'd1, V1);

        // Write and start in the same cycle: the run sees the new entry.
        run(5'd1, 1'b1, 4'd0, {2'd1, 2'd2, 4'd0, 8'd9}, cyc);
        check_eq("ws_fail", 32'(fail_count), 32'd1);
        check_eq("ws_exp", 32'(mismatch_expected), 32'd9);
        check_eq("ws_act", 32'(mismatch_actual), 32'd3);
        check_eq("ws_idx", 32'(mismatch_index), 32'd0);
        load(4'd0, V0);

        // Zero-length run finishes immediately, alu_* keep vector 0 of last run.
        run(5'd0, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("z_cycles", 32'(cyc), 32'd0);
        check_eq("z_done", 32'(done), 32'd1);
        check_eq("z_fail", 32'(fail_count), 32'd0);
        check_eq("z_mv", 32'(mismatch_valid), 32'd0);
        check_eq("z_alu_a", 32'(alu_a), 32'd1);
        check_eq("z_alu_b", 32'(alu_b), 32'd2);

        // Skip opcodes are never compared.
        use_model = 1'b0;
        load(4'd0, {2'd0, 2'd0, 4'd14, 8'h55});
        load(4'd1, {2'd1, 2'd1, 4'd15, 8'h00});
        run(5'd2, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("s_skip", 32'(skip_count), 32'd2);
        check_eq("s_pass", 32'(pass_count), 32'd0);
        check_eq("s_fail", 32'(fail_count), 32'd0);
        check_eq("s_mv", 32'(mismatch_valid), 32'd0);

        // vec_count above DEPTH is clamped to 16.
        for (int i = 0; i < 16; i++) load(4'(i), {2'd0, 2'd0, 4'd15, 8'd0});
        run(5'd20, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("c_skip", 32'(skip_count), 32'd16);
        check_eq("c_cycles", 32'(cyc), 32'(16 * PER));

        // Reset during WAIT of vector 2 of 4.
        use_model = 1'b1;
        load(4'd0, V0); load(4'd1, V1); load(4'd2, V2); load(4'd3, V3);
        @(negedge clock);
        vec_count = 5'd4; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2 * PER + 1) @(posedge clock);
        #1;
        check_eq("mr_alu_a", 32'(alu_a), 32'd2);
        check_eq("mr_pass", 32'(pass_count), 32'd2);
        check_eq("mr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_done", 32'(done), 32'd0);
        check_eq("ar_pass", 32'(pass_count), 32'd0);
        check_eq("ar_alu_a", 32'(alu_a), 32'd0);
        run(5'd4, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("rr_pass", 32'(pass_count), 32'd4);
        check_eq("rr_cycles", 32'(cyc), 32'(4 * PER));

        // start and load_we while busy are ignored.
        @(negedge clock);
        vec_count = 5'd4; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 500) begin
            @(posedge clock);
            #1 cyc++;
            if (cyc == 4) begin
                start = 1'b1; load_we = 1'b1; load_addr = 4'd0;
                load_data = {2'd3, 2'd3, 4'd0, 8'd0}; vec_count = 5'd1;
            end else begin
                start = 1'b0; load_we = 1'b0;
            end
        end
        start = 1'b0; load_we = 1'b0;
        check_eq("bi_cycles", 32'(cyc), 32'(4 * PER));
        check_eq("bi_pass", 32'(pass_count), 32'd4);
        check_eq("bi_fail", 32'(fail_count), 32'd0);
        run(5'd4, 1'b0, 4'd0, 16'd0, cyc);
        check_eq("bi_table_pass", 32'(pass_count), 32'd4);
        check_eq("bi_table_fail", 32'(fail_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
